// File: rtl/temp_pkg.sv
// temp_pkg
//   Shared definitions for the temperature level selector and the buzzer
//   stage downstream of it: the 2-bit level type, the four level codes and
//   a threshold classification helper.
//   The buzzer compares its sel input against LVL_HOT.
package temp_pkg;

   typedef logic [1:0] level_t;

   localparam level_t LVL_COLD   = 2'b00;
   localparam level_t LVL_NORMAL = 2'b01;
   localparam level_t LVL_WARM   = 2'b10;
   localparam level_t LVL_HOT    = 2'b11;

   // Maps a sample onto a level using three ascending lower bounds.
   function automatic level_t classify(input int unsigned t,
                                       input int unsigned th_cold,
                                       input int unsigned th_warm,
                                       input int unsigned th_hot);
      level_t lvl;
      if (t >= th_hot)       lvl = LVL_HOT;
      else if (t >= th_warm) lvl = LVL_WARM;
      else if (t >= th_cold) lvl = LVL_NORMAL;
      else                   lvl = LVL_COLD;
      return lvl;
   endfunction

endpackage

// File: rtl/temp_watchdog.sv
// temp_watchdog
//   Stale-data watchdog. Counts cycles since the last kick, saturating at
//   TIMEOUT_CYC. stale rises the cycle after the count has reached
//   TIMEOUT_CYC and drops the cycle after the next kick. A kick on the
//   expiry cycle wins, so stale never rises in that case.
// Ports:
//   clk    in   clock, posedge
//   rst_n  in   synchronous active-low reset
//   kick   in   one-cycle strobe: fresh data arrived
//   stale  out  registered watchdog-expired flag
module temp_watchdog #(
   parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic kick,
   output logic stale
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

   logic [CNT_W-1:0] cnt_reg;
   logic             stale_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_reg   <= '0;
         stale_reg <= 1'b0;
      end else if (kick) begin
         cnt_reg   <= '0;
         stale_reg <= 1'b0;
      end else if (cnt_reg == CNT_MAX) begin
         // Count holds at its ceiling; expiry is only flagged from here.
         stale_reg <= 1'b1;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign stale = stale_reg;

endmodule

// File: rtl/temp_level_sel.sv
// temp_level_sel
//   Classifies temperature samples into four levels for the buzzer stage,
//   with downward hysteresis, a persistence filter and a stale watchdog
//   that forces the hot level when the sensor goes quiet.
//   Optional feature macro: TEMP_HYST_EN. When defined, a level is only
//   left downward once the sample falls HYST below the bound; when
//   undefined, the same bounds apply in both directions.
// Ports:
//   clk         in   clock, posedge
//   rst_n       in   synchronous active-low reset
//   temp_valid  in   one-cycle strobe, temp valid this cycle
//   temp        in   DATA_W unsigned sample
//   sel         out  level to buzzer (00 cold, 01 normal, 10 warm, 11 hot)
//   level_chg   out  one-cycle pulse when the stored level changes
//   stale       out  high while the watchdog has expired
module temp_level_sel
   import temp_pkg::*;
#(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned T_COLD      = 15,
   parameter int unsigned T_WARM      = 30,
   parameter int unsigned T_HOT       = 40,
   parameter int unsigned HYST        = 2,
   parameter int unsigned PERSIST     = 4,
   parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              temp_valid,
   input  logic [DATA_W-1:0] temp,
   output logic [1:0]        sel,
   output logic              level_chg,
   output logic              stale
);

`ifdef TEMP_HYST_EN
   localparam int unsigned DN_HYST = HYST;
`else
   // Hysteresis disabled: the downward band collapses to zero.
   localparam int unsigned DN_HYST = 0 * HYST;
`endif

   // Downward bounds are elaboration-time constants; HYST < T_COLD keeps
   // them from wrapping.
   localparam int unsigned DN_COLD = T_COLD - DN_HYST;
   localparam int unsigned DN_WARM = T_WARM - DN_HYST;
   localparam int unsigned DN_HOT  = T_HOT  - DN_HYST;

   localparam int PCNT_W = $clog2(PERSIST + 1);
   localparam logic [PCNT_W-1:0] PCNT_TGT = PCNT_W'(PERSIST);

   level_t            level_reg;
   level_t            prev_cand_reg;
   logic [PCNT_W-1:0] pcnt_reg;
   logic              chg_reg;
   logic              stale_w;

   level_t            up_lvl;
   level_t            dn_lvl;
   level_t            cand;
   logic [PCNT_W-1:0] run_next;

   temp_watchdog #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_watchdog (
      .clk  (clk),
      .rst_n(rst_n),
      .kick (temp_valid),
      .stale(stale_w)
   );

   always_comb begin
      up_lvl = classify(32'(temp), T_COLD, T_WARM, T_HOT);
      dn_lvl = classify(32'(temp), DN_COLD, DN_WARM, DN_HOT);

      // Falling uses the relaxed bounds, rising the plain ones.
      cand = level_reg;
      if (dn_lvl < level_reg)      cand = dn_lvl;
      else if (up_lvl > level_reg) cand = up_lvl;

      // A run continues only while the same candidate keeps repeating.
      run_next = PCNT_W'(1);
      if ((pcnt_reg != '0) && (cand == prev_cand_reg))
         run_next = pcnt_reg + 1'b1;
   end

   // The filter only advances on valid samples, and a valid sample always
   // clears stale in the same cycle, so the filter is naturally frozen
   // for the whole stale period.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         level_reg     <= LVL_NORMAL;
         prev_cand_reg <= LVL_NORMAL;
         pcnt_reg      <= '0;
         chg_reg       <= 1'b0;
      end else begin
         chg_reg <= 1'b0;
         if (temp_valid) begin
            prev_cand_reg <= cand;
            if (cand == level_reg) begin
               pcnt_reg <= '0;
            end else if (run_next == PCNT_TGT) begin
               level_reg <= cand;
               pcnt_reg  <= '0;
               chg_reg   <= 1'b1;
            end else begin
               pcnt_reg <= run_next;
            end
         end
      end
   end

   // Built only from registers: no combinational path from the inputs.
   assign sel       = stale_w ? LVL_HOT : level_reg;
   assign level_chg = chg_reg;
   assign stale     = stale_w;

endmodule

// File: tb/tb_temp_level_sel.sv
// tb_temp_level_sel
//   Directed walk through the level selector's behaviours followed by
//   random samples, each cycle compared with a reference model built
//   from the classification rules.
module tb_temp_level_sel;

   localparam int TO      = 100;
   localparam int PERSIST = 4;
   localparam int TH_COLD = 15;
   localparam int TH_WARM = 30;
   localparam int TH_HOT  = 40;
`ifdef TEMP_HYST_EN
   localparam int MH = 2;
`else
   localparam int MH = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       temp_valid = 1'b0;
   logic [7:0] temp = '0;
   logic [1:0] sel;
   logic       level_chg;
   logic       stale;

   int errors = 0;
   int checks = 0;

   // reference model state
   int  m_lvl = 1;
   int  m_run = 0;
   int  m_last = 1;
   int  m_idle = 0;
   bit  m_chg = 0;

   always #5 clk = ~clk;

   temp_level_sel #(
      .DATA_W(8), .T_COLD(TH_COLD), .T_WARM(TH_WARM), .T_HOT(TH_HOT),
      .HYST(2), .PERSIST(PERSIST), .TIMEOUT_CYC(TO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .temp_valid(temp_valid),
      .temp      (temp),
      .sel       (sel),
      .level_chg (level_chg),
      .stale     (stale)
   );

   function automatic int lvl_of(input int t, input int h);
      int n = 0;
      if (t >= TH_COLD - h) n++;
      if (t >= TH_WARM - h) n++;
      if (t >= TH_HOT  - h) n++;
      return n;
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge(input bit r, input bit v, input int t);
      int up, dn, cand;
      if (!r) begin
         m_lvl = 1; m_run = 0; m_last = 1; m_idle = 0; m_chg = 0;
      end else begin
         m_chg = 0;
         if (v) begin
            m_idle = 0;
            up = lvl_of(t, 0);
            dn = lvl_of(t, MH);
            cand = (dn < m_lvl) ? dn : (up > m_lvl) ? up : m_lvl;
            if (cand == m_lvl) begin
               m_run = 0;
            end else begin
               m_run = (m_run > 0 && cand == m_last) ? m_run + 1 : 1;
               if (m_run == PERSIST) begin
                  m_lvl = cand; m_run = 0; m_chg = 1;
               end
            end
            m_last = cand;
         end else begin
            m_idle++;
         end
      end
   endtask

   // One clock: drive at negedge, model at posedge, compare 1 time unit later.
   task automatic step(input bit r, input bit v, input int t);
      bit exp_stale;
      @(negedge clk);
      rst_n = r; temp_valid = v; temp = 8'(t);
      @(posedge clk);
      model_edge(r, v, t);
      #1;
      exp_stale = (m_idle > TO);
      chk("stale", int'(stale), int'(exp_stale));
      chk("sel", int'(sel), exp_stale ? 3 : m_lvl);
      chk("level_chg", int'(level_chg), int'(m_chg));
   endtask

   task automatic samples(input int t, input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b1, t);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0);
   endtask

   initial begin
      // reset, then let the watchdog expire with no samples
      step(1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 0);
      idle(TO + 5);
      // one sample of 20 while stale: back to normal, no pulse
      samples(20, 1);
      idle(3);
      // four samples of 42: normal -> hot
      samples(42, 4);
      idle(2);
      // hysteresis from hot: 39 then 37
      samples(39, 4);
      idle(2);
      samples(37, 4);
      idle(2);
      // back to normal, then alternating 42/10
      samples(20, 4);
      for (int i = 0; i < 5; i++) begin
         samples(42, 1);
         samples(10, 1);
      end
      // three hot samples interrupted by a warm one
      samples(42, 3);
      samples(35, 1);
      idle(2);
      // reset mid-filter, then one more hot sample
      samples(20, 4);
      samples(42, 3);
      step(1'b0, 1'b0, 0);
      samples(42, 1);
      // sample landing exactly on the expiry cycle
      idle(TO);
      samples(20, 1);
      idle(TO - 1);
      samples(25, 1);
      // randomized stream
      for (int i = 0; i < 2500; i++) begin
         bit r = ($urandom_range(0, 199) != 0);
         bit v = ($urandom_range(0, 2) == 0);
         int t = $urandom_range(0, 60);
         step(r, v, t);
         if ($urandom_range(0, 299) == 0) idle(TO + $urandom_range(0, 3) - 1);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
